// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit.
// A single state register walks each instruction through fetch, decode,
// execute, memory and write-back phases. All datapath controls are
// combinational decodes of the current state (plus mem_ready for the
// fetch handshake) and are forced to zero while reset is held, so an
// asynchronous reset kills any in-flight memory access immediately.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       JumpAndLink,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal_op
);

    // State encoding is visible on the debug port, so it is pinned here.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        RWB    = 4'd7,
        EXEC_I = 4'd8,
        IWB    = 4'd9,
        BRANCH = 4'd10,
        JAL    = 4'd11
    } ctrlState_t;

    // Supported opcodes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operation codes.
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    // ALU B operand selects.
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source selects.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operation for the immediate-arithmetic group. The opcode stays
    // stable in the instruction register, so the write-back cycle can
    // re-derive the same value instead of storing it.
    function automatic logic [2:0] immAluOp(input logic [5:0] op);
        logic [2:0] aluSel;
        case (op)
            OP_ANDI: aluSel = ALU_AND;
            OP_ORI:  aluSel = ALU_OR;
            default: aluSel = ALU_ADD;
        endcase
        return aluSel;
    endfunction

    ctrlState_t stateR;
    ctrlState_t nextStateS;

    logic       pcWriteS;
    logic       pcWriteCondS;
    logic       iorDS;
    logic       memReadS;
    logic       memWriteS;
    logic       irWriteS;
    logic       memtoRegS;
    logic       regDstS;
    logic       jumpAndLinkS;
    logic       regWriteS;
    logic       aluSrcAS;
    logic [1:0] aluSrcBS;
    logic [2:0] aluOpS;
    logic [1:0] pcSourceS;
    logic       illegalOpS;

    // State register: asynchronous reset parks the machine in FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR <= FETCH;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Next-state and control decode; everything defaults low so a state
    // only lists the controls it actually drives.
    always_comb begin
        nextStateS   = FETCH;
        pcWriteS     = 1'b0;
        pcWriteCondS = 1'b0;
        iorDS        = 1'b0;
        memReadS     = 1'b0;
        memWriteS    = 1'b0;
        irWriteS     = 1'b0;
        memtoRegS    = 1'b0;
        regDstS      = 1'b0;
        jumpAndLinkS = 1'b0;
        regWriteS    = 1'b0;
        aluSrcAS     = 1'b0;
        aluSrcBS     = SRCB_RT;
        aluOpS       = ALU_ADD;
        pcSourceS    = PCSRC_ALU;
        illegalOpS   = 1'b0;

        if (reset) begin
            // Hold every control low while reset is applied, including the
            // fetch read that FETCH would otherwise request.
            nextStateS = FETCH;
        end else begin
            case (stateR)
                FETCH: begin
                    memReadS  = 1'b1;
                    iorDS     = 1'b0;
                    aluSrcAS  = 1'b0;
                    aluSrcBS  = SRCB_FOUR;
                    aluOpS    = ALU_ADD;
                    pcSourceS = PCSRC_ALU;
                    // IR load and PC+4 commit only when the read completes.
                    irWriteS  = mem_ready;
                    pcWriteS  = mem_ready;
                    if (mem_ready) begin
                        nextStateS = DECODE;
                    end else begin
                        nextStateS = FETCH;
                    end
                end
                DECODE: begin
                    // Precompute the branch target while the opcode decodes.
                    aluSrcAS = 1'b0;
                    aluSrcBS = SRCB_IMMSH;
                    aluOpS   = ALU_ADD;
                    case (op_code)
                        OP_RTYPE:                 nextStateS = EXEC_R;
                        OP_LW, OP_SW:             nextStateS = MEMADR;
                        OP_ADDI, OP_ANDI, OP_ORI: nextStateS = EXEC_I;
                        OP_BEQ:                   nextStateS = BRANCH;
                        OP_JAL:                   nextStateS = JAL;
                        default: begin
                            nextStateS = FETCH;
                            illegalOpS = 1'b1;
                        end
                    endcase
                end
                MEMADR: begin
                    aluSrcAS = 1'b1;
                    aluSrcBS = SRCB_IMM;
                    aluOpS   = ALU_ADD;
                    if (op_code == OP_LW) begin
                        nextStateS = MEMRD;
                    end else begin
                        nextStateS = MEMWR;
                    end
                end
                MEMRD: begin
                    memReadS = 1'b1;
                    iorDS    = 1'b1;
                    if (mem_ready) begin
                        nextStateS = MEMWB;
                    end else begin
                        nextStateS = MEMRD;
                    end
                end
                MEMWB: begin
                    regWriteS  = 1'b1;
                    memtoRegS  = 1'b1;
                    regDstS    = 1'b0;
                    nextStateS = FETCH;
                end
                MEMWR: begin
                    memWriteS = 1'b1;
                    iorDS     = 1'b1;
                    if (mem_ready) begin
                        nextStateS = FETCH;
                    end else begin
                        nextStateS = MEMWR;
                    end
                end
                EXEC_R: begin
                    aluSrcAS   = 1'b1;
                    aluSrcBS   = SRCB_RT;
                    aluOpS     = ALU_FUNCT;
                    nextStateS = RWB;
                end
                RWB: begin
                    regWriteS  = 1'b1;
                    regDstS    = 1'b1;
                    memtoRegS  = 1'b0;
                    nextStateS = FETCH;
                end
                EXEC_I: begin
                    aluSrcAS   = 1'b1;
                    aluSrcBS   = SRCB_IMM;
                    aluOpS     = immAluOp(op_code);
                    nextStateS = IWB;
                end
                IWB: begin
                    regWriteS  = 1'b1;
                    regDstS    = 1'b0;
                    memtoRegS  = 1'b0;
                    aluOpS     = immAluOp(op_code);
                    nextStateS = FETCH;
                end
                BRANCH: begin
                    aluSrcAS     = 1'b1;
                    aluSrcBS     = SRCB_RT;
                    aluOpS       = ALU_SUB;
                    pcWriteCondS = 1'b1;
                    pcSourceS    = PCSRC_ALUOUT;
                    nextStateS   = FETCH;
                end
                JAL: begin
                    pcWriteS     = 1'b1;
                    pcSourceS    = PCSRC_JUMP;
                    regWriteS    = 1'b1;
                    jumpAndLinkS = 1'b1;
                    nextStateS   = FETCH;
                end
                default: begin
                    // Unused codes drive nothing and recover to FETCH.
                    nextStateS = FETCH;
                end
            endcase
        end
    end

    // Drive the ports from the decode results.
    always_comb begin
        PCWrite     = pcWriteS;
        PCWriteCond = pcWriteCondS;
        IorD        = iorDS;
        MemRead     = memReadS;
        MemWrite    = memWriteS;
        IRWrite     = irWriteS;
        MemtoReg    = memtoRegS;
        RegDst      = regDstS;
        JumpAndLink = jumpAndLinkS;
        RegWrite    = regWriteS;
        ALUSrcA     = aluSrcAS;
        ALUSrcB     = aluSrcBS;
        ALUOp       = aluOpS;
        PCSource    = pcSourceS;
        illegal_op  = illegalOpS;
        state       = stateR;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instruction
// sequences push the expected control word per cycle, a negedge monitor
// pops and compares against the DUT.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op_code;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, JumpAndLink, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       illegal_op;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op_code(op_code), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .JumpAndLink(JumpAndLink),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       jal;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic       illegal;
        logic [3:0] st;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    function automatic obs_t observe();
        obs_t o;
        o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, JumpAndLink, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             illegal_op, state};
        return o;
    endfunction

    // Expected control word for a state, written from the state table.
    function automatic obs_t expFor(logic [3:0] st, logic mr, logic [5:0] op);
        obs_t e;
        e = '0;
        e.st = st;
        case (st)
            4'd0: begin e.memRead = 1'b1; e.aluSrcB = 2'b01; e.irWrite = mr; e.pcWrite = mr; end
            4'd1: begin
                e.aluSrcB = 2'b11;
                if (!(op inside {6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h03}))
                    e.illegal = 1'b1;
            end
            4'd2: begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
            4'd3: begin e.memRead = 1'b1; e.iorD = 1'b1; end
            4'd4: begin e.regWrite = 1'b1; e.memtoReg = 1'b1; end
            4'd5: begin e.memWrite = 1'b1; e.iorD = 1'b1; end
            4'd6: begin e.aluSrcA = 1'b1; e.aluOp = 3'b010; end
            4'd7: begin e.regWrite = 1'b1; e.regDst = 1'b1; end
            4'd8: begin
                e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
                e.aluOp = (op == 6'h0C) ? 3'b011 : ((op == 6'h0D) ? 3'b100 : 3'b000);
            end
            4'd9: begin
                e.regWrite = 1'b1;
                e.aluOp = (op == 6'h0C) ? 3'b011 : ((op == 6'h0D) ? 3'b100 : 3'b000);
            end
            4'd10: begin e.aluSrcA = 1'b1; e.aluOp = 3'b001; e.pcWriteCond = 1'b1; e.pcSource = 2'b01; end
            4'd11: begin e.pcWrite = 1'b1; e.pcSource = 2'b10; e.regWrite = 1'b1; e.jal = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input obs_t act, input obs_t exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Drive one cycle of inputs and queue the response expected in it.
    task automatic issue(input logic [5:0] op, input logic mr, input logic [3:0] st, input string tag);
        exp_t e;
        obs_t z;
        z = '0;
        op_code   = op;
        mem_ready = mr;
        e.v   = reset ? z : expFor(st, mr, op);
        e.tag = tag;
        expQ.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare queued expectations and the memory/write-enable rules.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check(e.tag, observe(), e.v);
        end
        if (!reset) begin
            checkCount++;
            if (!(MemRead && MemWrite) && !(RegWrite && (state inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5})))
                passCount++;
            else
                $display("FAIL invariant: state=%0d MemRead=%b MemWrite=%b RegWrite=%b",
                         state, MemRead, MemWrite, RegWrite);
        end
    end

    initial begin
        obs_t zero;
        zero      = '0;
        reset     = 1'b1;
        mem_ready = 1'b1;
        op_code   = 6'h00;
        #2;
        issue(6'h00, 1'b1, 4'd0, "reset_a");
        issue(6'h00, 1'b1, 4'd0, "reset_b");
        reset = 1'b0;

        // R-type: 0,1,6,7
        issue(6'h00, 1'b1, 4'd0,  "r_fetch");
        issue(6'h00, 1'b1, 4'd1,  "r_decode");
        issue(6'h00, 1'b1, 4'd6,  "r_exec");
        issue(6'h00, 1'b1, 4'd7,  "r_wb");
        // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4
        issue(6'h23, 1'b1, 4'd0,  "lw_fetch");
        issue(6'h23, 1'b1, 4'd1,  "lw_decode");
        issue(6'h23, 1'b1, 4'd2,  "lw_memadr");
        issue(6'h23, 1'b0, 4'd3,  "lw_memrd_wait1");
        issue(6'h23, 1'b0, 4'd3,  "lw_memrd_wait2");
        issue(6'h23, 1'b1, 4'd3,  "lw_memrd_done");
        issue(6'h23, 1'b1, 4'd4,  "lw_memwb");
        // sw: 0,1,2,5
        issue(6'h2B, 1'b1, 4'd0,  "sw_fetch");
        issue(6'h2B, 1'b1, 4'd1,  "sw_decode");
        issue(6'h2B, 1'b1, 4'd2,  "sw_memadr");
        issue(6'h2B, 1'b1, 4'd5,  "sw_memwr");
        // addi / andi / ori: 0,1,8,9
        issue(6'h08, 1'b1, 4'd0,  "addi_fetch");
        issue(6'h08, 1'b1, 4'd1,  "addi_decode");
        issue(6'h08, 1'b1, 4'd8,  "addi_exec");
        issue(6'h08, 1'b1, 4'd9,  "addi_wb");
        issue(6'h0C, 1'b1, 4'd0,  "andi_fetch");
        issue(6'h0C, 1'b1, 4'd1,  "andi_decode");
        issue(6'h0C, 1'b1, 4'd8,  "andi_exec");
        issue(6'h0C, 1'b1, 4'd9,  "andi_wb");
        issue(6'h0D, 1'b1, 4'd0,  "ori_fetch");
        issue(6'h0D, 1'b1, 4'd1,  "ori_decode");
        issue(6'h0D, 1'b1, 4'd8,  "ori_exec");
        issue(6'h0D, 1'b1, 4'd9,  "ori_wb");
        // beq: 0,1,10
        issue(6'h04, 1'b1, 4'd0,  "beq_fetch");
        issue(6'h04, 1'b1, 4'd1,  "beq_decode");
        issue(6'h04, 1'b1, 4'd10, "beq_branch");
        // jal with a one-cycle fetch stall: 0,0,1,11
        issue(6'h03, 1'b0, 4'd0,  "jal_fetch_stall");
        issue(6'h03, 1'b1, 4'd0,  "jal_fetch");
        issue(6'h03, 1'b1, 4'd1,  "jal_decode");
        issue(6'h03, 1'b1, 4'd11, "jal_link");
        // unsupported opcode: 0,1(illegal),0
        issue(6'h3F, 1'b1, 4'd0,  "ill_fetch");
        issue(6'h3F, 1'b1, 4'd1,  "ill_decode");
        issue(6'h3F, 1'b1, 4'd0,  "ill_back_to_fetch");
        issue(6'h3F, 1'b0, 4'd1,  "ill_refetch_done");
        // sw stalled in MEMWR, then asynchronous reset mid-access
        issue(6'h2B, 1'b1, 4'd0,  "swr_fetch");
        issue(6'h2B, 1'b1, 4'd1,  "swr_decode");
        issue(6'h2B, 1'b1, 4'd2,  "swr_memadr");
        issue(6'h2B, 1'b0, 4'd5,  "swr_memwr_wait");
        check("swr_memwr_held", observe(), expFor(4'd5, 1'b0, 6'h2B));
        #1 reset = 1'b1;
        #1 check("async_reset_abort", observe(), zero);
        issue(6'h2B, 1'b1, 4'd0,  "reset_hold_mr1");
        reset = 1'b0;
        // Recovery after reset: R-type again
        issue(6'h00, 1'b1, 4'd0,  "rec_fetch");
        issue(6'h00, 1'b1, 4'd1,  "rec_decode");
        issue(6'h00, 1'b1, 4'd6,  "rec_exec");
        issue(6'h00, 1'b1, 4'd7,  "rec_wb");
        issue(6'h00, 1'b1, 4'd0,  "rec_fetch2");

        repeat (2) @(posedge clk);
        checkCount++;
        if (expQ.size() == 0) passCount++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
